// File: rtl/button_conditioner.sv
// Nine-button front end: two-flop synchronizers, per-bit debounce, one-clock press
// pulses, and auto-repeat on the four direction buttons.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned REPEAT_DELAY    = 32500000,
    parameter int unsigned REPEAT_PERIOD   = 6500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] btn_raw,
    output logic [8:0] btn_level,
    output logic [8:0] btn_press,
    output logic       any_press
);

    localparam int unsigned N_BTN   = 9;
    localparam int unsigned N_DIR   = 4;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic {
        MODE_FIRST  = 1'b0,
        MODE_REPEAT = 1'b1
    } mode_e;

    logic [N_BTN-1:0] sync_meta_q, sync_meta_d;
    logic [N_BTN-1:0] sync_q, sync_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic             any_press_q, any_press_d;
    logic [DB_W-1:0]  db_cnt_q [N_BTN];
    logic [DB_W-1:0]  db_cnt_d [N_BTN];
    logic [RPT_W-1:0] rpt_cnt_q [N_DIR];
    logic [RPT_W-1:0] rpt_cnt_d [N_DIR];
    mode_e            mode_q [N_DIR];
    mode_e            mode_d [N_DIR];
    logic [RPT_W-1:0] rpt_last;

    // Next-state: synchronize, debounce, then derive press / repeat pulses.
    always_comb begin
        sync_meta_d = btn_raw;
        sync_d      = sync_meta_q;
        level_d     = level_q;
        rpt_last    = FIRST_LAST;

        for (int i = 0; i < int'(N_BTN); i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end

        press_d = level_d & ~level_q;

        // Repeat only while held across the edge; a release on the firing edge wins.
        for (int j = 0; j < int'(N_DIR); j++) begin
            rpt_cnt_d[j] = '0;
            mode_d[j]    = MODE_FIRST;
            if (level_q[j] && level_d[j]) begin
                rpt_last  = (mode_q[j] == MODE_FIRST) ? FIRST_LAST : RPT_LAST;
                mode_d[j] = mode_q[j];
                if (rpt_cnt_q[j] == rpt_last) begin
                    press_d[j] = 1'b1;
                    mode_d[j]  = MODE_REPEAT;
                end else begin
                    rpt_cnt_d[j] = rpt_cnt_q[j] + RPT_W'(1);
                end
            end
        end

        any_press_d = |press_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            level_q     <= '0;
            press_q     <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int j = 0; j < int'(N_DIR); j++) begin
                rpt_cnt_q[j] <= '0;
                mode_q[j]    <= MODE_FIRST;
            end
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            level_q     <= level_d;
            press_q     <= press_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int j = 0; j < int'(N_DIR); j++) begin
                rpt_cnt_q[j] <= rpt_cnt_d[j];
                mode_q[j]    <= mode_d[j];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a sliding-window reference model pushes the
// expected outputs for every edge; a negedge monitor pops and compares.
module tb_button_conditioner;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    typedef struct packed {
        logic [8:0] level;
        logic [8:0] press;
        logic       any;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] btn_raw = '0;
    logic [8:0] btn_level;
    logic [8:0] btn_press;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    logic [8:0] hist[$];
    logic [8:0] m_level = '0;
    int         t_edge = 0;
    int         press_t[4];

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .any_press(any_press)
    );

    always #5 clk = ~clk;

    // Raw value sampled k edges before the current one; before reset release it reads 0.
    function automatic logic [8:0] sample_back(int k);
        int idx;
        idx = hist.size() - k;
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_level = '0;
        t_edge  = 0;
        for (int b = 0; b < 4; b++) press_t[b] = 0;
    endfunction

    // Reference: level flips once the raw input has disagreed with it for DEB samples,
    // two samples back (synchronizer); repeats fire DELAY after the press, then every PERIOD.
    always @(posedge clk) begin
        exp_t       e;
        logic [8:0] new_level;
        logic [8:0] press;
        logic [8:0] s;
        logic       all_diff;
        int         d;
        if (!reset_n) begin
            model_reset();
            e = '0;
        end else begin
            t_edge++;
            new_level = m_level;
            for (int b = 0; b < 9; b++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= DEB + 1; k++) begin
                    s = sample_back(k);
                    if (s[b] == m_level[b]) all_diff = 1'b0;
                end
                if (all_diff) new_level[b] = ~m_level[b];
            end
            press = new_level & ~m_level;
            for (int b = 0; b < 4; b++) begin
                if (press[b]) begin
                    press_t[b] = t_edge;
                end else if (m_level[b] && new_level[b]) begin
                    d = t_edge - press_t[b];
                    if (d == DELAY || (d > DELAY && (d - DELAY) % PERIOD == 0)) press[b] = 1'b1;
                end
            end
            hist.push_back(btn_raw);
            if (hist.size() > DEB + 2) void'(hist.pop_front());
            m_level = new_level;
            e.level = new_level;
            e.press = press;
            e.any   = |press;
        end
        exp_q.push_back(e);
    end

    // Asynchronous reset clears outputs at once: replace this cycle's expectation.
    always @(negedge reset_n) begin
        model_reset();
        if (exp_q.size() != 0) begin
            exp_q.delete();
            exp_q.push_back('0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (btn_level !== e.level || btn_press !== e.press || any_press !== e.any) begin
                errors++;
                $display("FAIL outputs at %0t: got level=%b press=%b any=%b, want level=%b press=%b any=%b",
                         $time, btn_level, btn_press, any_press, e.level, e.press, e.any);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
    endtask

    initial begin
        int hold[9];
        int got[$];
        int want[4] = '{6, 16, 19, 22};
        logic ok;

        step(3);
        reset_n = 1'b1;
        step(2);

        // Enter held: single press, no repeat.
        btn_raw[4] = 1'b1;
        step(40);
        btn_raw[4] = 1'b0;
        step(10);

        // Left held: press and repeat edges checked directly.
        btn_raw[0] = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            if (btn_press[0]) got.push_back(n);
            #1;
        end
        ok = (got.size() == 4);
        if (ok) for (int i = 0; i < 4; i++) if (got[i] != want[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL left_repeat_edges: got %p, want %p", got, want);
        end
        btn_raw[0] = 1'b0;
        step(12);

        // Up glitch shorter than debounce.
        btn_raw[2] = 1'b1;
        step(3);
        btn_raw[2] = 1'b0;
        step(10);

        // Right and two together.
        btn_raw[1] = 1'b1;
        btn_raw[7] = 1'b1;
        step(12);
        btn_raw = '0;
        step(10);

        // Reset while left held, then re-qualification.
        btn_raw[0] = 1'b1;
        step(11);
        pulse_reset();
        step(30);
        btn_raw = '0;
        step(10);

        // Randomized bouncy holds on all buttons, with occasional resets.
        for (int b = 0; b < 9; b++) hold[b] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 9; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    hold[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(5, 40));
                end
            end
            if ($urandom_range(0, 599) == 0) pulse_reset();
            else step(1);
        end
        btn_raw = '0;
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
